// File: rtl/store_commit_ctrl.sv
// Store commit controller: in-order store queue released on ROB commit, arbitrating one memory port with the load unit.
// Optional feature macro MISALIGN_TRAP_EN: misaligned committed stores are dropped and flagged instead of written.
module store_commit_ctrl #(
    parameter int         DEPTH       = 4,
    parameter logic [5:0] INVALID_ROB = 6'b010000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        storeEnable,
    input  logic [5:0]  storeRob,
    input  logic [31:0] storeData,
    input  logic [31:0] storeAddr,
    input  logic [2:0]  storeSubType,
    output logic        available,
    input  logic        commitEnable,
    input  logic [5:0]  commitRob,
    input  logic        flush,
    input  logic        loadReq,
    input  logic [31:0] loadAddr,
    output logic        loadDone,
    output logic [31:0] loadData,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [3:0]  memMask,
    input  logic [31:0] memRdata,
    input  logic        memDone,
    output logic        misalign
);
    // state | meaning
    // IDLE  | port free; choose committed head store or pending load
    // STORE | write of head entry outstanding, waiting for memDone
    // LOAD  | read for load unit outstanding, waiting for memDone
    typedef enum logic [1:0] {IDLE, STORE, LOAD} state_t;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    state_t state, state_next;

    logic [5:0]  q_rob  [DEPTH];
    logic [31:0] q_data [DEPTH];
    logic [31:0] q_addr [DEPTH];
    logic [2:0]  q_sub  [DEPTH];

    logic [PTR_W-1:0] head, commit_ptr, tail;
    logic [CNT_W-1:0] count, committed_count;
    logic             last_load, last_load_next;

    logic        mem_req_next, mem_we_next, load_done_next, misalign_next;
    logic [31:0] mem_addr_next, mem_wdata_next, load_data_next;
    logic [3:0]  mem_mask_next;
    logic        pop, commit_fire, enq, store_ready, load_ready;
    logic [3:0]  lane_mask;
    logic [31:0] lane_wdata;
    logic        head_misaligned;

    assign available   = count < FULL;
    assign commit_fire = commitEnable && (committed_count < count) && (q_rob[commit_ptr] == commitRob);
    assign enq         = storeEnable && available && !flush;
    assign store_ready = committed_count != '0;
    // loadReq may still be high in the cycle loadDone is shown; that request is already served.
    assign load_ready  = loadReq && !loadDone;

    always_comb begin
        lane_mask  = 4'b1111;
        lane_wdata = q_data[head];
        case (q_sub[head])
            3'b000: begin
                lane_mask  = 4'b0001 << q_addr[head][1:0];
                lane_wdata = {4{q_data[head][7:0]}};
            end
            3'b001: begin
                lane_mask  = q_addr[head][1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{q_data[head][15:0]}};
            end
            default: ;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        case (q_sub[head])
            3'b000:  head_misaligned = 1'b0;
            3'b001:  head_misaligned = q_addr[head][0];
            default: head_misaligned = q_addr[head][1:0] != 2'b00;
        endcase
    end
`else
    assign head_misaligned = 1'b0;
`endif

    always_comb begin
        state_next     = state;
        mem_req_next   = memReq;
        mem_we_next    = memWe;
        mem_addr_next  = memAddr;
        mem_wdata_next = memWdata;
        mem_mask_next  = memMask;
        load_done_next = 1'b0;
        load_data_next = loadData;
        misalign_next  = 1'b0;
        last_load_next = last_load;
        pop            = 1'b0;
        case (state)
            IDLE: begin
                if (store_ready && (!load_ready || last_load)) begin
                    last_load_next = 1'b0;
                    if (head_misaligned) begin
                        pop           = 1'b1;
                        misalign_next = 1'b1;
                    end else begin
                        state_next     = STORE;
                        mem_req_next   = 1'b1;
                        mem_we_next    = 1'b1;
                        mem_addr_next  = q_addr[head] & 32'hFFFF_FFFC;
                        mem_wdata_next = lane_wdata;
                        mem_mask_next  = lane_mask;
                    end
                end else if (load_ready) begin
                    state_next     = LOAD;
                    mem_req_next   = 1'b1;
                    mem_we_next    = 1'b0;
                    mem_addr_next  = loadAddr & 32'hFFFF_FFFC;
                    mem_wdata_next = 32'h0;
                    mem_mask_next  = 4'b0000;
                end
            end
            STORE: begin
                if (memDone) begin
                    pop            = 1'b1;
                    mem_req_next   = 1'b0;
                    mem_we_next    = 1'b0;
                    last_load_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            LOAD: begin
                if (memDone) begin
                    load_done_next = 1'b1;
                    load_data_next = memRdata;
                    mem_req_next   = 1'b0;
                    last_load_next = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            head            <= '0;
            commit_ptr      <= '0;
            tail            <= '0;
            count           <= '0;
            committed_count <= '0;
            last_load       <= 1'b0;
            memReq          <= 1'b0;
            memWe           <= 1'b0;
            memAddr         <= 32'h0;
            memWdata        <= 32'h0;
            memMask         <= 4'b0000;
            loadDone        <= 1'b0;
            loadData        <= 32'h0;
            misalign        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) q_rob[i] <= INVALID_ROB;
        end else begin
            state      <= state_next;
            last_load  <= last_load_next;
            memReq     <= mem_req_next;
            memWe      <= mem_we_next;
            memAddr    <= mem_addr_next;
            memWdata   <= mem_wdata_next;
            memMask    <= mem_mask_next;
            loadDone   <= load_done_next;
            loadData   <= load_data_next;
            misalign   <= misalign_next;
            head       <= head + PTR_W'(pop);
            commit_ptr <= commit_ptr + PTR_W'(commit_fire);
            committed_count <= committed_count + CNT_W'(commit_fire) - CNT_W'(pop);
            if (enq) q_rob[tail] <= storeRob;
            // Flush trims the uncommitted tail after this cycle's commit has been taken.
            if (flush) begin
                tail  <= commit_ptr + PTR_W'(commit_fire);
                count <= committed_count + CNT_W'(commit_fire) - CNT_W'(pop);
            end else begin
                tail  <= tail + PTR_W'(enq);
                count <= count + CNT_W'(enq) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            q_data[tail] <= storeData;
            q_addr[tail] <= storeAddr;
            q_sub[tail]  <= storeSubType;
        end
    end

endmodule

// File: tb/tb_store_commit_ctrl.sv
// Randomized bench for store_commit_ctrl against a queue-based reference model of the store queue and port arbiter.
// Build with MISALIGN_TRAP_EN defined to exercise the misaligned-store trap in both DUT and model.
module tb_store_commit_ctrl;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        storeEnable = 1'b0;
    logic [5:0]  storeRob = '0;
    logic [31:0] storeData = '0, storeAddr = '0;
    logic [2:0]  storeSubType = '0;
    logic        available;
    logic        commitEnable = 1'b0;
    logic [5:0]  commitRob = '0;
    logic        flush = 1'b0;
    logic        loadReq = 1'b0;
    logic [31:0] loadAddr = '0;
    logic        loadDone;
    logic [31:0] loadData;
    logic        memReq, memWe;
    logic [31:0] memAddr, memWdata;
    logic [3:0]  memMask;
    logic [31:0] memRdata = '0;
    logic        memDone = 1'b0;
    logic        misalign;

    store_commit_ctrl #(.DEPTH(DEPTH), .INVALID_ROB(6'b010000)) dut (
        .clock(clock), .reset(reset),
        .storeEnable(storeEnable), .storeRob(storeRob), .storeData(storeData),
        .storeAddr(storeAddr), .storeSubType(storeSubType), .available(available),
        .commitEnable(commitEnable), .commitRob(commitRob), .flush(flush),
        .loadReq(loadReq), .loadAddr(loadAddr), .loadDone(loadDone), .loadData(loadData),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memMask(memMask), .memRdata(memRdata), .memDone(memDone), .misalign(misalign)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]  rob;
        logic [31:0] data;
        logic [31:0] addr;
        logic [2:0]  sub;
        bit          committed;
    } ent_t;

    ent_t        mq[$];
    int          busy = 0;          // 0 none, 1 store outstanding, 2 load outstanding
    bit          last_load = 0;
    logic        e_req = 0, e_we = 0, e_ldone = 0, e_mis = 0;
    logic [31:0] e_addr = 0, e_wdata = 0, e_ldata = 0;
    logic [3:0]  e_mask = 0;

    int n_checks = 0, n_fail = 0;
    bit md_pending = 0;
    int md_delay = 0;
    bit rand_load = 0;
    logic [5:0] next_rob = 6'd0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void lanes(input logic [2:0] sub, input logic [31:0] a, input logic [31:0] d,
                                  output logic [3:0] m, output logic [31:0] w);
        case (sub)
            3'd0: begin m = 4'b0001 << a[1:0]; w = {4{d[7:0]}}; end
            3'd1: begin m = a[1] ? 4'b1100 : 4'b0011; w = {2{d[15:0]}}; end
            default: begin m = 4'b1111; w = d; end
        endcase
    endfunction

    function automatic bit is_misaligned(input logic [2:0] sub, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        if (sub == 3'd0) return 1'b0;
        if (sub == 3'd1) return a[0];
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_edge();
        int  ncomm;
        int  pre_size;
        bit  pop, new_ldone, new_mis, sr, lr;
        if (reset) begin
            mq.delete();
            busy = 0; last_load = 0;
            e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_mask = 0;
            e_ldone = 0; e_ldata = 0; e_mis = 0;
            return;
        end
        ncomm = 0;
        foreach (mq[i]) if (mq[i].committed) ncomm++;
        pop = 0; new_ldone = 0; new_mis = 0;
        if (busy == 1) begin
            if (memDone) begin pop = 1; busy = 0; e_req = 0; e_we = 0; last_load = 0; end
        end else if (busy == 2) begin
            if (memDone) begin new_ldone = 1; e_ldata = memRdata; busy = 0; e_req = 0; last_load = 1; end
        end else begin
            sr = ncomm > 0;
            lr = loadReq && !e_ldone;
            if (sr && (!lr || last_load)) begin
                last_load = 0;
                if (is_misaligned(mq[0].sub, mq[0].addr)) begin
                    pop = 1; new_mis = 1;
                end else begin
                    busy = 1; e_req = 1; e_we = 1;
                    e_addr = {mq[0].addr[31:2], 2'b00};
                    lanes(mq[0].sub, mq[0].addr, mq[0].data, e_mask, e_wdata);
                end
            end else if (lr) begin
                busy = 2; e_req = 1; e_we = 0;
                e_addr = {loadAddr[31:2], 2'b00};
                e_wdata = 0; e_mask = 0;
            end
        end
        if (commitEnable && ncomm < mq.size() && mq[ncomm].rob == commitRob)
            mq[ncomm].committed = 1;
        pre_size = mq.size();
        if (pop) void'(mq.pop_front());
        if (flush) begin
            while (mq.size() > 0 && !mq[mq.size()-1].committed) void'(mq.pop_back());
        end else if (storeEnable && pre_size < DEPTH) begin
            mq.push_back('{rob: storeRob, data: storeData, addr: storeAddr, sub: storeSubType, committed: 0});
        end
        e_ldone = new_ldone;
        e_mis = new_mis;
    endtask

    task automatic step();
        bit was_reset;
        @(posedge clock);
        model_edge();
        was_reset = reset;
        #1;
        check_val("available", 32'(available), 32'(mq.size() < DEPTH));
        check_val("memReq", 32'(memReq), 32'(e_req));
        if (e_req || was_reset) begin
            check_val("memWe", 32'(memWe), 32'(e_we));
            check_val("memAddr", memAddr, e_addr);
            if (e_we || was_reset) begin
                check_val("memWdata", memWdata, e_wdata);
                check_val("memMask", 32'(memMask), 32'(e_mask));
            end
        end
        check_val("loadDone", 32'(loadDone), 32'(e_ldone));
        check_val("loadData", loadData, e_ldata);
        check_val("misalign", 32'(misalign), 32'(e_mis));
        storeEnable = 0; commitEnable = 0; flush = 0; reset = 0; memDone = 0;
        memRdata = $urandom;
        if (was_reset) md_pending = 0;
        if (memReq && !md_pending) begin md_pending = 1; md_delay = $urandom_range(0, 3); end
        if (md_pending) begin
            if (md_delay == 0) begin memDone = 1; md_pending = 0; end
            else md_delay--;
        end
        if (loadDone) loadReq = 0;
        else if (rand_load && !loadReq && ($urandom_range(0, 3) == 0)) begin
            loadReq = 1; loadAddr = $urandom;
        end
    endtask

    task automatic enq(input logic [5:0] rob, input logic [31:0] d, input logic [31:0] a, input logic [2:0] sub);
        storeEnable = 1; storeRob = rob; storeData = d; storeAddr = a; storeSubType = sub;
        step();
    endtask

    task automatic commit(input logic [5:0] rob);
        commitEnable = 1; commitRob = rob;
        step();
    endtask

    task automatic drain();
        int n = 0;
        while ((mq.size() != 0 || busy != 0 || loadReq) && n < 300) begin step(); n++; end
        check_val("drain_queue", 32'(mq.size()), 32'd0);
        check_val("drain_port", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1; step();
        reset = 1; step();
    endtask

    initial begin
        do_reset();
        enq(6'd3, 32'hDEADBEEF, 32'h104, 3'd2); commit(6'd3); drain();
        enq(6'd4, 32'h000000AB, 32'h203, 3'd0); commit(6'd4); drain();
        enq(6'd5, 32'h00001234, 32'h202, 3'd1); commit(6'd5); drain();
        for (int i = 0; i < 5; i++) enq(6'(10 + i), $urandom, $urandom, 3'd2);
        for (int i = 0; i < 4; i++) commit(6'(10 + i));
        drain();
        enq(6'd5, 32'h5, 32'h500, 3'd2); enq(6'd6, 32'h6, 32'h600, 3'd2); enq(6'd7, 32'h7, 32'h700, 3'd2);
        commit(6'd5); commit(6'd6);
        flush = 1; step();
        drain();
        enq(6'd30, 32'h30, 32'h30, 3'd2); enq(6'd31, 32'h31, 32'h31, 3'd2);
        commitEnable = 1; commitRob = 6'd30; flush = 1; storeEnable = 1; storeRob = 6'd32; step();
        drain();
        enq(6'd9, 32'h9, 32'h102, 3'd2); commit(6'd9); drain();
        // Arbitration ties starting from a fresh reset
        do_reset();
        enq(6'd20, 32'h11112222, 32'h300, 3'd2); commit(6'd20);
        loadReq = 1; loadAddr = 32'h40; step();
        drain();
        enq(6'd21, 32'h33334444, 32'h304, 3'd2); commit(6'd21);
        loadReq = 1; loadAddr = 32'h44; step();
        drain();
        // Reset while a write is outstanding, then a stray memDone
        enq(6'd40, 32'h40, 32'h500, 3'd2); commit(6'd40);
        for (int i = 0; i < 20 && !memReq; i++) step();
        check_val("wait_memReq", 32'(memReq), 32'd1);
        reset = 1; step();
        memDone = 1; step();
        step();
        rand_load = 1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                storeEnable = 1; storeRob = next_rob; next_rob = next_rob + 6'd1;
                storeData = $urandom; storeAddr = $urandom; storeSubType = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 2) == 0) begin
                int nc = 0;
                foreach (mq[i]) if (mq[i].committed) nc++;
                commitEnable = 1;
                commitRob = (nc < mq.size() && $urandom_range(0, 3) != 0) ? mq[nc].rob : 6'($urandom);
            end
            if ($urandom_range(0, 59) == 0) flush = 1;
            if ($urandom_range(0, 499) == 0) reset = 1;
            step();
        end
        rand_load = 0;
        flush = 1; step();
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
